// File: rtl/trap_csr.sv
// Machine-mode trap CSR bank: mstatus/mie/mtvec/mscratch/mepc/mcause/mip, trap entry, MRET, IRQ pending/priority.
// Optional IRQ_SYNC_EN adds a metastability flop ahead of the IRQ capture register.
module trap_csr #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          MSCRATCH_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_WAIT,
  input  logic [2:0]  IRQ,
  input  logic        TRAP_EN,
  input  logic        TRAP_IS_INT,
  input  logic [31:0] TRAP_CODE,
  input  logic [31:0] TRAP_PC,
  input  logic        MRET,
  input  logic        CSR_EN,
  input  logic [1:0]  CSR_OP,
  input  logic [11:0] CSR_ADDR,
  input  logic [31:0] CSR_WDATA,
  output logic [31:0] CSR_RDATA,
  output logic        CSR_ILLEGAL,
  output logic        INT_ALLOW,
  output logic        INT_EN,
  output logic [3:0]  INT_CODE,
  output logic [1:0]  TRAP_VEC_MODE,
  output logic [31:0] TRAP_VEC_BASE,
  output logic [31:0] MRET_PC
);

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [2:0]  mie_en_q, mie_en_d;          // [0]=bit3, [1]=bit7, [2]=bit11
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [2:0]  irq_s_q, irq_s_d;
  logic        int_en_q, int_en_d;
  logic [3:0]  int_code_q, int_code_d;

  logic [2:0]  irq_in;
  logic [2:0]  pend;
  logic        legal;
  logic [31:0] rd;
  logic [31:0] wval;
  logic        csr_wr;
  logic        unused_trap_code;

  assign unused_trap_code = ^TRAP_CODE[31:4];

`ifdef IRQ_SYNC_EN
  // First synchronizer stage; irq_s_q acts as the second stage.
  logic [2:0] irq_meta_q;
  always_ff @(posedge CLK) begin
    if (RST)            irq_meta_q <= '0;
    else if (!MEM_WAIT) irq_meta_q <= IRQ;
  end
  assign irq_in = irq_meta_q;
`else
  assign irq_in = IRQ;
`endif

  always_comb begin
    legal = 1'b1;
    rd    = '0;
    case (CSR_ADDR)
      12'h300: rd = {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      12'h304: rd = {20'b0, mie_en_q[2], 3'b0, mie_en_q[1], 3'b0, mie_en_q[0], 3'b0};
      12'h305: rd = mtvec_q;
      12'h340: begin
        legal = MSCRATCH_EN;
        rd    = MSCRATCH_EN ? mscratch_q : '0;
      end
      12'h341: rd = mepc_q;
      12'h342: rd = mcause_q;
      12'h344: rd = {20'b0, irq_s_q[2], 3'b0, irq_s_q[1], 3'b0, irq_s_q[0], 3'b0};
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    case (CSR_OP)
      2'b01:   wval = CSR_WDATA;
      2'b10:   wval = rd | CSR_WDATA;
      2'b11:   wval = rd & ~CSR_WDATA;
      default: wval = rd;
    endcase
  end

  assign csr_wr = CSR_EN && legal && (CSR_OP != 2'b00);
  assign pend   = irq_s_q & mie_en_q;

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_en_d       = mie_en_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    irq_s_d        = irq_in;
    int_en_d       = |pend;
    int_code_d     = pend[2] ? 4'd11 : pend[0] ? 4'd3 : pend[1] ? 4'd7 : 4'd0;
    if (TRAP_EN) begin
      mepc_d         = TRAP_PC & ~32'd3;
      mcause_d       = {TRAP_IS_INT, 27'b0, TRAP_CODE[3:0]};
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (MRET) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (csr_wr) begin
      case (CSR_ADDR)
        12'h300: begin
          mstatus_mie_d  = wval[3];
          mstatus_mpie_d = wval[7];
        end
        12'h304: mie_en_d   = {wval[11], wval[7], wval[3]};
        12'h305: mtvec_d    = {wval[31:2], wval[1] ? 2'b00 : wval[1:0]};
        12'h340: mscratch_d = wval;
        12'h341: mepc_d     = wval & ~32'd3;
        12'h342: mcause_d   = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_en_q       <= '0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      irq_s_q        <= '0;
      int_en_q       <= 1'b0;
      int_code_q     <= '0;
    end else if (!MEM_WAIT) begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_en_q       <= mie_en_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      irq_s_q        <= irq_s_d;
      int_en_q       <= int_en_d;
      int_code_q     <= int_code_d;
    end
  end

  assign CSR_RDATA     = rd;
  assign CSR_ILLEGAL   = CSR_EN && !legal;
  assign INT_ALLOW     = mstatus_mie_q;
  assign INT_EN        = int_en_q;
  assign INT_CODE      = int_code_q;
  assign TRAP_VEC_MODE = mtvec_q[1:0];
  assign TRAP_VEC_BASE = {mtvec_q[31:2], 2'b00};
  assign MRET_PC       = mepc_q;

endmodule

// File: tb/tb_trap_csr.sv
// Directed self-checking bench for trap_csr with hand-computed expectations.
module tb_trap_csr;

`ifdef IRQ_SYNC_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 2;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        MEM_WAIT;
  logic [2:0]  IRQ;
  logic        TRAP_EN;
  logic        TRAP_IS_INT;
  logic [31:0] TRAP_CODE;
  logic [31:0] TRAP_PC;
  logic        MRET;
  logic        CSR_EN;
  logic [1:0]  CSR_OP;
  logic [11:0] CSR_ADDR;
  logic [31:0] CSR_WDATA;
  logic [31:0] CSR_RDATA;
  logic        CSR_ILLEGAL;
  logic        INT_ALLOW;
  logic        INT_EN;
  logic [3:0]  INT_CODE;
  logic [1:0]  TRAP_VEC_MODE;
  logic [31:0] TRAP_VEC_BASE;
  logic [31:0] MRET_PC;

  int n_cmp = 0;
  int n_mis = 0;

  trap_csr #(.MTVEC_RESET(32'h0000_0101), .MSCRATCH_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .MEM_WAIT(MEM_WAIT), .IRQ(IRQ),
    .TRAP_EN(TRAP_EN), .TRAP_IS_INT(TRAP_IS_INT), .TRAP_CODE(TRAP_CODE),
    .TRAP_PC(TRAP_PC), .MRET(MRET), .CSR_EN(CSR_EN), .CSR_OP(CSR_OP),
    .CSR_ADDR(CSR_ADDR), .CSR_WDATA(CSR_WDATA), .CSR_RDATA(CSR_RDATA),
    .CSR_ILLEGAL(CSR_ILLEGAL), .INT_ALLOW(INT_ALLOW), .INT_EN(INT_EN),
    .INT_CODE(INT_CODE), .TRAP_VEC_MODE(TRAP_VEC_MODE),
    .TRAP_VEC_BASE(TRAP_VEC_BASE), .MRET_PC(MRET_PC)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] addr, input string tag, input logic [31:0] exp);
    CSR_EN   = 1'b0;
    CSR_OP   = 2'b00;
    CSR_ADDR = addr;
    #1;
    chk(tag, CSR_RDATA, exp);
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    CSR_EN    = 1'b1;
    CSR_OP    = op;
    CSR_ADDR  = addr;
    CSR_WDATA = wd;
    tick();
    CSR_EN    = 1'b0;
    CSR_OP    = 2'b00;
  endtask

  initial begin
    RST = 1'b1; MEM_WAIT = 1'b0; IRQ = '0;
    TRAP_EN = 1'b0; TRAP_IS_INT = 1'b0; TRAP_CODE = '0; TRAP_PC = '0;
    MRET = 1'b0; CSR_EN = 1'b0; CSR_OP = '0; CSR_ADDR = '0; CSR_WDATA = '0;
    tick(); tick();
    RST = 1'b0;

    // Reset state
    rd(12'h305, "rst_mtvec", 32'h0000_0101);
    rd(12'h300, "rst_mstatus", 32'h0);
    rd(12'h341, "rst_mepc", 32'h0);
    chk("rst_vec_base", TRAP_VEC_BASE, 32'h0000_0100);
    chk("rst_vec_mode", {30'b0, TRAP_VEC_MODE}, 32'd1);
    chk("rst_int_allow", {31'b0, INT_ALLOW}, 32'd0);
    chk("rst_int_en", {31'b0, INT_EN}, 32'd0);
    chk("rst_int_code", {28'b0, INT_CODE}, 32'd0);
    chk("rst_mret_pc", MRET_PC, 32'd0);
    chk("rst_illegal", {31'b0, CSR_ILLEGAL}, 32'd0);

    // mtvec WARL
    csr(2'b01, 12'h305, 32'h0000_1003);
    chk("mtvec3_mode", {30'b0, TRAP_VEC_MODE}, 32'd0);
    chk("mtvec3_base", TRAP_VEC_BASE, 32'h0000_1000);
    rd(12'h305, "mtvec3_rd", 32'h0000_1000);
    csr(2'b01, 12'h305, 32'h0000_2001);
    chk("mtvec1_mode", {30'b0, TRAP_VEC_MODE}, 32'd1);
    chk("mtvec1_base", TRAP_VEC_BASE, 32'h0000_2000);
    csr(2'b01, 12'h305, 32'h0000_3002);
    rd(12'h305, "mtvec2_rd", 32'h0000_3000);

    // Enable MIE and external interrupt, then raise IRQ[2]
    csr(2'b10, 12'h300, 32'h0000_0008);
    chk("mie_allow", {31'b0, INT_ALLOW}, 32'd1);
    rd(12'h300, "mstatus_set", 32'h0000_0008);
    csr(2'b10, 12'h304, 32'h0000_0800);
    rd(12'h304, "mie_rd", 32'h0000_0800);
    IRQ = 3'b100;
    for (int unsigned i = 1; i < LAT; i++) begin
      tick();
      chk("irq_lat_early", {31'b0, INT_EN}, 32'd0);
    end
    tick();
    chk("irq_ext_en", {31'b0, INT_EN}, 32'd1);
    chk("irq_ext_code", {28'b0, INT_CODE}, 32'd11);
    rd(12'h344, "mip_rd", 32'h0000_0800);

    // Trap entry then MRET
    TRAP_EN = 1'b1; TRAP_IS_INT = 1'b1; TRAP_CODE = 32'd11; TRAP_PC = 32'h0000_0104;
    tick();
    TRAP_EN = 1'b0; TRAP_IS_INT = 1'b0;
    rd(12'h341, "trap_mepc", 32'h0000_0104);
    rd(12'h342, "trap_mcause", 32'h8000_000B);
    rd(12'h300, "trap_mstatus", 32'h0000_0080);
    chk("trap_allow", {31'b0, INT_ALLOW}, 32'd0);
    MRET = 1'b1;
    #1;
    chk("mret_pc", MRET_PC, 32'h0000_0104);
    tick();
    MRET = 1'b0;
    rd(12'h300, "mret_mstatus", 32'h0000_0088);
    chk("mret_allow", {31'b0, INT_ALLOW}, 32'd1);

    // Coincident trap, MRET and CSR write: only trap lands
    csr(2'b01, 12'h340, 32'h55AA_1234);
    rd(12'h340, "mscratch_rd", 32'h55AA_1234);
    TRAP_EN = 1'b1; TRAP_IS_INT = 1'b0; TRAP_CODE = 32'hFFFF_FFF2; TRAP_PC = 32'h0000_0203;
    MRET = 1'b1;
    csr(2'b01, 12'h340, 32'h0000_DEAD);
    TRAP_EN = 1'b0; MRET = 1'b0;
    rd(12'h340, "coinc_mscratch", 32'h55AA_1234);
    rd(12'h341, "coinc_mepc", 32'h0000_0200);
    rd(12'h342, "coinc_mcause", 32'h0000_0002);
    rd(12'h300, "coinc_mstatus", 32'h0000_0080);

    // Same under MEM_WAIT: nothing moves, IRQ capture frozen too
    MEM_WAIT = 1'b1; IRQ = 3'b000;
    TRAP_EN = 1'b1; TRAP_IS_INT = 1'b1; TRAP_CODE = 32'd5; TRAP_PC = 32'h0000_0300;
    MRET = 1'b1;
    csr(2'b01, 12'h340, 32'h0000_BEEF);
    tick(); tick();
    TRAP_EN = 1'b0; MRET = 1'b0;
    rd(12'h340, "stall_mscratch", 32'h55AA_1234);
    rd(12'h341, "stall_mepc", 32'h0000_0200);
    rd(12'h342, "stall_mcause", 32'h0000_0002);
    rd(12'h300, "stall_mstatus", 32'h0000_0080);
    chk("stall_int_en", {31'b0, INT_EN}, 32'd1);
    chk("stall_int_code", {28'b0, INT_CODE}, 32'd11);
    MEM_WAIT = 1'b0;
    for (int unsigned i = 0; i < LAT; i++) tick();
    chk("unstall_int_en", {31'b0, INT_EN}, 32'd0);
    chk("unstall_int_code", {28'b0, INT_CODE}, 32'd0);

    // Illegal address and mip write
    CSR_EN = 1'b1; CSR_OP = 2'b01; CSR_ADDR = 12'h7C0; CSR_WDATA = 32'hFFFF_FFFF;
    #1;
    chk("illegal_flag", {31'b0, CSR_ILLEGAL}, 32'd1);
    chk("illegal_rdata", CSR_RDATA, 32'd0);
    CSR_ADDR = 12'h344;
    #1;
    chk("mip_wr_legal", {31'b0, CSR_ILLEGAL}, 32'd0);
    tick();
    CSR_EN = 1'b0; CSR_OP = 2'b00;
    rd(12'h344, "mip_wr_ignored", 32'h0);

    // Software vs timer priority, then clear software enable
    csr(2'b01, 12'h304, 32'h0000_0088);
    IRQ = 3'b011;
    for (int unsigned i = 0; i < LAT; i++) tick();
    chk("sw_tmr_en", {31'b0, INT_EN}, 32'd1);
    chk("sw_tmr_code", {28'b0, INT_CODE}, 32'd3);
    csr(2'b11, 12'h304, 32'h0000_0008);
    rd(12'h304, "mie_clr", 32'h0000_0080);
    tick();
    chk("tmr_code", {28'b0, INT_CODE}, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/trap_csr.md
Name: trap_csr

Overview:
Machine-mode trap CSR bank; consumer end of the trap unit's output interface. Captures TRAP_EN/TRAP_PC/TRAP_CODE into mepc/mcause/mstatus, serves CSR instructions from the exec stage, and executes MRET. Also sources the trap unit's inputs: INT_ALLOW, INT_EN, INT_CODE, TRAP_VEC_MODE and TRAP_VEC_BASE, with interrupt pending and priority logic. Sits beside the exec stage, between the trap unit and the fetch redirect.

Parameters:
MTVEC_RESET, 32'h0000_0000, mtvec value after reset (mode field included).
MSCRATCH_EN, 1, 1 implements mscratch (0x340); 0 makes 0x340 illegal.

Ports:
CLK  in  1  clock
RST  in  1  reset: synchronous, active-high
MEM_WAIT  in  1  pipeline stall; freezes all state
IRQ  in  3  level interrupt lines: [0] software, [1] timer, [2] external
TRAP_EN  in  1  trap taken this cycle (from trap unit)
TRAP_IS_INT  in  1  taken trap is an interrupt
TRAP_CODE  in  32  cause code; only [3:0] used
TRAP_PC  in  32  faulting/interrupted PC
MRET  in  1  exec stage retiring MRET
CSR_EN  in  1  CSR instruction valid in exec
CSR_OP  in  2  00 none, 01 write, 10 set, 11 clear
CSR_ADDR  in  12  CSR address
CSR_WDATA  in  32  operand
CSR_RDATA  out  32  old CSR value (combinational)
CSR_ILLEGAL  out  1  CSR_EN to an unimplemented address
INT_ALLOW  out  1  mstatus.MIE
INT_EN  out  1  an enabled interrupt is pending
INT_CODE  out  4  highest-priority pending cause
TRAP_VEC_MODE  out  2  mtvec[1:0]
TRAP_VEC_BASE  out  32  {mtvec[31:2],2'b00}
MRET_PC  out  32  mepc; valid when MRET

Behaviour:
- Registers: mstatus 0x300 (only MIE bit3 and MPIE bit7 are writable; all other bits read 0), mie 0x304 (bits 3, 7, 11 writable), mtvec 0x305, mscratch 0x340, mepc 0x341 ([1:0] forced 0), mcause 0x342, mip 0x344 (read-only: bit3=irq_s[0], bit7=irq_s[1], bit11=irq_s[2]).
- Reset: mtvec=MTVEC_RESET; all other registers and irq_s are 0.
  - Resulting outputs after reset: INT_ALLOW=0, INT_EN=0, INT_CODE=0, MRET_PC=0, CSR_ILLEGAL=0, CSR_RDATA=0 for any address except mtvec.
- MEM_WAIT=1 freezes every register, including the IRQ capture; outputs hold.
- CSR access:
  - CSR_RDATA is the pre-update value of CSR_ADDR.
  - Write takes effect at the next clock edge: op 01 gives new=WDATA, 10 gives old|WDATA, 11 gives old&~WDATA.
  - op 00, or a write to mip, leaves state unchanged and is not illegal.
  - Unimplemented address with CSR_EN=1: CSR_ILLEGAL=1 (combinational), CSR_RDATA=0, no update.
- mtvec WARL: a written mode of 2 or 3 is stored as 0; base bits stored as written.
- Trap entry (TRAP_EN=1, no stall), all at one edge:
  - mepc<=TRAP_PC&~3
  - mcause<={TRAP_IS_INT,27'b0,TRAP_CODE[3:0]}
  - MPIE<=MIE
  - MIE<=0
- MRET (no stall): MIE<=MPIE, MPIE<=1. MRET_PC equals the current mepc in the same cycle.
- Priority when events coincide: TRAP_EN > MRET > CSR write. A lower-priority event in the same cycle is dropped entirely.
- Interrupts:
  - pend = mip & mie.
  - INT_EN and INT_CODE are registered one cycle after pend.
  - INT_EN=|pend; INT_EN is not gated by MIE (the trap unit ANDs it with INT_ALLOW).
  - Priority: external (11) > software (3) > timer (7). INT_CODE=0 when nothing is pending.
- Latency:
  - IRQ rise to INT_EN=1 is 2 cycles (irq_s capture plus INT_EN register).
  - A CSR write to MIE/mie reaches INT_ALLOW next cycle and INT_EN one cycle later.

Optional Feature:
IRQ_SYNC_EN:
- Defined: each IRQ line passes a 2-flop synchronizer before irq_s. IRQ to INT_EN latency becomes 3 cycles. Synchronizer flops reset to 0 and freeze under MEM_WAIT.
- Undefined: single capture register, 2-cycle latency.

Test Plan:
- Reset, then read 0x305 and 0x300 -> CSR_RDATA=MTVEC_RESET, then 0; INT_ALLOW=0; TRAP_VEC_BASE=MTVEC_RESET&~3.
- Write mtvec=32'h0000_1003 -> TRAP_VEC_MODE=0, TRAP_VEC_BASE=32'h1000; write 32'h0000_2001 -> mode 1, base 32'h2000.
- Set MIE; set mie bit 11; raise IRQ[2] -> INT_EN=1, INT_CODE=11 exactly 2 cycles later (3 with IRQ_SYNC_EN); INT_ALLOW=1.
- TRAP_EN with TRAP_IS_INT=1, TRAP_CODE=11, TRAP_PC=32'h0000_0104 -> mepc=32'h104, mcause=32'h8000_000B, MIE=0, MPIE=1; then MRET -> MRET_PC=32'h104, MIE=1, MPIE=1.
- TRAP_EN, MRET and CSR write to mscratch in the same cycle -> only the trap updates state; mscratch unchanged. Repeat with MEM_WAIT=1 -> nothing changes.
- CSR_EN to 0x7C0 -> CSR_ILLEGAL=1, CSR_RDATA=0; IRQ[0] and IRQ[1] both pending and enabled -> INT_CODE=3.
